// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and SR/Cause field positions.
// Pure declarations; no latency and no backpressure.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    localparam int SR_IE       = 0;
    localparam int SR_EXL      = 1;
    localparam int SR_IM_SW_LO = 8;
    localparam int SR_IM_LO    = 10;
    localparam int CAUSE_EXC_LO   = 2;
    localparam int CAUSE_IP_SW_LO = 8;
    localparam int CAUSE_IP_LO    = 10;
    localparam int CAUSE_BD       = 31;

endpackage

// File: rtl/cp0_int_pend.sv
// Pending-interrupt evaluation: any unmasked pending line while IE=1 and EXL=0.
// Purely combinational; no backpressure.
module cp0_int_pend
    import cp0_pkg::*;
(
    input  logic [7:0] pend,
    input  logic [7:0] mask,
    input  logic       ie,
    input  logic       exl,
    output logic       int_req
);

    assign int_req = (|(pend & mask)) & ie & ~exl;

endmodule

// File: rtl/cp0_unit.sv
// CP0 register file and exception/interrupt arbitration; req is same-cycle, state updates next edge.
// No backpressure. Software interrupt bits IP/IM[9:8] exist only with CP0_SW_INT_EN defined.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  sel,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [31:0] vpc,
    input  logic        bd,
    input  logic [4:0]  exc_code,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        req,
    output logic [31:0] epc_out
);

    logic [5:0]  im_hw;
    logic [1:0]  im_sw;
    logic        exl;
    logic        ie;
    logic        bd_r;
    logic [5:0]  ip_hw;
    logic [1:0]  ip_sw;
    logic [4:0]  exc_r;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic [31:0] epc_entry;
    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic        mtc0_epc;

    cp0_int_pend u_int_pend (
        .pend    ({hw_int, ip_sw}),
        .mask    ({im_hw, im_sw}),
        .ie      (ie),
        .exl     (exl),
        .int_req (int_req)
    );

    assign exc_req = (exc_code != 5'd0) & ~exl;
    assign req     = int_req | exc_req;

    assign epc_entry = bd ? (vpc - 32'd4) : vpc;
    assign mtc0_epc  = we & (sel == REG_EPC) & ~req;
    assign epc_out   = mtc0_epc ? {wdata[31:2], 2'b00} : epc;

    assign sr_val    = {16'b0, im_hw, im_sw, 6'b0, exl, ie};
    assign cause_val = {bd_r, 15'b0, ip_hw, ip_sw, 1'b0, exc_r, 2'b00};

    always_comb begin
        rdata = 32'h0;
        case (sel)
            REG_SR:    rdata = sr_val;
            REG_CAUSE: rdata = cause_val;
            REG_EPC:   rdata = epc;
            REG_PRID:  rdata = PRID_VAL;
            default:   rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_hw <= '0;
            exl   <= 1'b0;
            ie    <= 1'b0;
            bd_r  <= 1'b0;
            ip_hw <= '0;
            exc_r <= '0;
            epc   <= '0;
        end else begin
            ip_hw <= hw_int;
            if (req) begin
                exl   <= 1'b1;
                bd_r  <= bd;
                exc_r <= int_req ? EXC_INT : exc_code;
                epc   <= epc_entry & ~32'h3;
            end else begin
                if (we && sel == REG_SR) begin
                    im_hw <= wdata[SR_IM_LO +: 6];
                    exl   <= wdata[SR_EXL];
                    ie    <= wdata[SR_IE];
                end
                if (mtc0_epc)
                    epc <= {wdata[31:2], 2'b00};
                // eret is ordered after mtc0 SR so it wins on a same-cycle EXL write
                if (eret)
                    exl <= 1'b0;
            end
        end
    end

`ifdef CP0_SW_INT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            im_sw <= '0;
            ip_sw <= '0;
        end else if (we && !req) begin
            if (sel == REG_SR)
                im_sw <= wdata[SR_IM_SW_LO +: 2];
            if (sel == REG_CAUSE)
                ip_sw <= wdata[CAUSE_IP_SW_LO +: 2];
        end
    end
`else
    assign im_sw = 2'b00;
    assign ip_sw = 2'b00;
`endif

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 block for the pipelined MIPS CPU. It is the consumer of the timer IRQ lines (`int_time0`, `int_time1`) and the external `interrupt`, and it owns the SR, Cause, EPC and PRId registers. It arbitrates interrupts against synchronous exceptions reported by the M stage and raises a flush/redirect request. It serves `mfc0`, `mtc0` and `eret` from the M stage.

## Interface
Parameters:
- `PRID_VAL`, default 32'h0000_0000: read-only value of PRId (reg 15).

Ports:
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high.
- `sel` input 5: CP0 register number for `mfc0`/`mtc0`.
- `we` input 1: `mtc0` write enable (M stage).
- `wdata` input 32: `mtc0` data.
- `rdata` output 32: `mfc0` read data.
- `vpc` input 32: PC of the M-stage instruction (macroscopic PC).
- `bd` input 1: M-stage instruction is in a delay slot.
- `exc_code` input 5: synchronous exception code from the pipeline. 0 means none; any nonzero value is an exception.
- `hw_int` input 6: {3'b0, `interrupt`, `int_time1`, `int_time0`}.
- `eret` input 1: `eret` in M stage.
- `req` output 1: take exception/interrupt; flush the pipeline and redirect to the handler.
- `epc_out` output 32: return address for `eret`.

## Operation
Registers and their writable fields:
- **SR (12):** IM[15:10], EXL[1], IE[0]. These bits are writable; all other bits read 0.
- **Cause (13):** BD[31], IP[15:10], ExcCode[6:2]. Not writable by `mtc0`.
- **EPC (14):** fully writable. Bits [1:0] are forced to 0 on every write.
- **PRId (15):** returns `PRID_VAL`.
- Any other `sel` reads 0.

Request logic (`int_req`, `exc_req` and `req` are combinational):
- `int_req` = |(`hw_int` & IM) & IE & !EXL.
- `exc_req` = (`exc_code` != 0) & !EXL.
- `req` = `int_req` | `exc_req`.

On a clock edge with `req` = 1:
- EXL <= 1.
- BD <= `bd`.
- ExcCode <= 0 if `int_req`, else `exc_code`. Interrupt beats exception.
- EPC <= (`bd` ? `vpc`-4 : `vpc`) with [1:0] cleared.

Other update rules:
- Cause.IP[15:10] <= `hw_int` every cycle, regardless of EXL or `req`.
- `mtc0` takes effect only when `req` = 0. When `req` = 1 in the same cycle, the write is dropped.
- `eret` clears EXL when `req` = 0. When `req` = 1 in the same cycle, the exception entry wins.
- `rdata` is a combinational read of the current register value, with no write bypass.
- `epc_out` = (`we` & `sel`==14 & !`req`) ? {`wdata`[31:2],2'b0} : EPC. This forwards an `mtc0 EPC` that precedes `eret`.

## Timing
- `req` is combinational in the same cycle its inputs are presented. All register updates happen on the next rising edge.
- `mtc0` results are visible on `rdata` one cycle later.
- On `reset`, SR, Cause and EPC all go to 0 on the edge. At reset: `req` = 0, `rdata` = 0 for sel 12/13/14, `epc_out` = 0.
- While EXL = 1, `req` stays 0 for all inputs, so there is no nesting.
- If `reset` is asserted in the same cycle as `req`, reset wins and all registers go to 0.
- `vpc`-4 wraps modulo 2^32.

## Configuration
- **`CP0_SW_INT_EN` defined:**
  - Cause.IP[9:8] are software-interrupt bits, writable by `mtc0` to Cause.
  - SR.IM[9:8] is writable.
  - `int_req` also includes |(IP[9:8] & IM[9:8]).
- **`CP0_SW_INT_EN` undefined:** those four bits read 0, ignore writes, and never raise `req`.

## Structure
- **Shared package:**
  - Register numbers: SR=12, CAUSE=13, EPC=14, PRID=15.
  - ExcCode constants: INT=0, ADEL=4, ADES=5, SYSCALL=8, RI=10, OV=12.
  - SR/Cause bit positions.
- **Sub-module `cp0_int_pend`:** combinational pending-interrupt evaluation producing `int_req` from IP, IM, IE, EXL (and software bits when enabled). It is reused by the top-level arbitration.

## Test plan
1. **Reset values:** assert `reset` for one cycle; read `sel`=12, 13, 14 -> `rdata` = 0 each; `req` = 0.
2. **Timer interrupt entry:** `mtc0` SR=32'h0000_0401; next cycle `hw_int`=6'b000001, `vpc`=32'h0000_3008, `bd`=0 -> `req`=1 that cycle. Next cycle: Cause=32'h0000_0400, EPC=32'h0000_3008, SR=32'h0000_0403, `req`=0.
3. **Overflow in delay slot:** SR=0, `exc_code`=12, `bd`=1, `vpc`=32'h0000_3010 -> `req`=1. Next cycle: EPC=32'h0000_300C, Cause=32'h8000_0030.
4. **Interrupt beats exception and drops mtc0:** SR=32'h0000_0401, `hw_int`[0]=1, `exc_code`=10, `we`=1, `sel`=14, `wdata`=32'h1234 in the same cycle -> ExcCode=0, EPC=`vpc`, mtc0 discarded.
5. **EPC forward then eret:** `mtc0` EPC with `wdata`=32'h0000_3003 -> `epc_out`=32'h0000_3000 in that same cycle. Next cycle `eret` with EXL=1 -> EXL=0 on the following cycle.
6. **Masking under EXL:** EXL=1, `hw_int`=6'b000111, `exc_code`=4 -> `req`=0. Cause.IP reads 32'h0000_1C00 one cycle later.
